// File: rtl/adder_share_arbiter.sv
// Shared 64-bit address adder (unsigned base + signed offset) with a
// round-robin arbiter in front and a one-entry registered result slot behind.
//
// Handshakes:
//   request side: requester k transfers in a cycle where i_req[k] & o_gnt[k].
//     A raised request keeps i_req/i_a/i_b stable until it is granted.
//   result side:  o_res/o_res_id are consumed in a cycle where
//     o_res_valid & i_res_ready. While o_res_valid=1 and i_res_ready=0 the
//     slot holds and no grant is issued.
module adder_share_arbiter #(
    parameter int W    = 64,
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*W-1:0] i_a,
    input  logic [NREQ*W-1:0] i_b,
    output logic [NREQ-1:0]   o_gnt,
    output logic [W-1:0]      o_res,
    output logic              o_res_valid,
    output logic [IDW-1:0]    o_res_id,
    input  logic              i_res_ready,
    output logic              o_dbg_state,
    output logic [IDW-1:0]    o_dbg_ptr
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    slot_state_t    state;
    slot_state_t    state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] gnt_idx;
    logic           found;
    logic           can_accept;
    logic           xfer;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   sum;

    assign o_res_valid = (state == S_FULL);
    assign o_dbg_state = state;
    assign o_dbg_ptr   = ptr;

    // The slot can take a new result when it is empty or is being drained now.
    assign can_accept = !o_res_valid || i_res_ready;

    // Round-robin search starting at ptr: first requester found wins.
    always_comb begin : arb_search
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && i_req[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // One-hot grant, suppressed during reset and while the slot is blocked.
    always_comb begin
        o_gnt = '0;
        if (i_rst_n && can_accept && found) begin
            o_gnt[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |(i_req & o_gnt);

    // Operand select for the winner; the offset is already W bits wide, so
    // its two's-complement value adds directly and wraps modulo 2^W.
    always_comb begin
        a_sel = i_a[int'(gnt_idx)*W +: W];
        b_sel = i_b[int'(gnt_idx)*W +: W];
        sum   = a_sel + b_sel;
    end

    // Pointer moves to the requester after the winner, wrapping to 0.
    assign ptr_nxt = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

    // Slot state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot next state: fill on transfer, empty on drain without refill.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (xfer) begin
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (i_res_ready && !xfer) begin
                    state_nxt = S_EMPTY;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Result, id and round-robin pointer load only on a transfer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_res    <= '0;
            o_res_id <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            o_res    <= sum;
            o_res_id <= gnt_idx;
            ptr      <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed literal cases followed by random
// traffic, all checked against a queue-based model of the result slot.
module tb_adder_share_arbiter;

    localparam int W    = 64;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_bus;
    logic [NREQ*W-1:0] b_bus;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      res;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic              dbg_state;
    logic [IDW-1:0]    dbg_ptr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model state: pending result slot as queues, arbitration pointer.
    logic [W-1:0]    exp_q[$];
    int              id_q[$];
    int              m_ptr = 0;
    logic [NREQ-1:0] m_gnt = '0;
    logic [NREQ-1:0] last_gnt = '0;

    adder_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_a         (a_bus),
        .i_b         (b_bus),
        .o_gnt       (gnt),
        .o_res       (res),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .i_res_ready (res_ready),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand64();
        case ($urandom_range(0, 3))
            0:       rand64 = {W{1'b1}} - W'($urandom_range(0, 15));
            1:       rand64 = W'($urandom_range(0, 64));
            default: rand64 = {$urandom, $urandom};
        endcase
    endfunction

    // Compare process: expected grant from the round-robin rule, expected
    // outputs from the head of the result queue.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NREQ-1:0] eg;
            int k;
            eg = '0;
            if (rst_n && (exp_q.size() == 0 || res_ready)) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (m_ptr + i) % NREQ;
                    if (eg == '0 && req[k]) eg[k] = 1'b1;
                end
            end
            m_gnt = eg;
            check("gnt", gnt, eg);
            check("valid", res_valid, exp_q.size() != 0);
            check("state", dbg_state, exp_q.size() != 0);
            check("ptr", dbg_ptr, m_ptr);
            if (exp_q.size() != 0) begin
                check("res", res, exp_q[0]);
                check("id", res_id, id_q[0]);
            end
        end
    end

    // Model update at the active edge.
    always @(posedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                exp_q.delete();
                id_q.delete();
                m_ptr    = 0;
                last_gnt = '0;
            end else begin
                if (exp_q.size() != 0 && res_ready) begin
                    void'(exp_q.pop_front());
                    void'(id_q.pop_front());
                end
                last_gnt = m_gnt;
                for (int k = 0; k < NREQ; k++) begin
                    if (m_gnt[k]) begin
                        exp_q.push_back(a_bus[k*W +: W] + b_bus[k*W +: W]);
                        id_q.push_back(k);
                        m_ptr = (k + 1) % NREQ;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed cases with literal expectations, then random traffic.
    initial begin
        bit prev_rst_low;
        rst_n     = 1'b0;
        req       = 2'b11;
        a_bus     = '0;
        b_bus     = '0;
        res_ready = 1'b1;

        // Reset for two cycles with both requesting.
        next_cycle();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_gnt", gnt, 2'b00);
        next_cycle();
        @(negedge clk);
        check("rst_valid", res_valid, 1'b0);
        check("rst_res", res, 64'h0);
        check("rst_id", res_id, 1'b0);
        @(posedge clk);
        #1;

        // Single request: 0x400000 + (-8).
        rst_n = 1'b1;
        req   = 2'b01;
        a_bus[0 +: W] = 64'h40_0000;
        b_bus[0 +: W] = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        check("single_gnt", gnt, 2'b01);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        check("single_res", res, 64'h3F_FFF8);
        check("single_valid", res_valid, 1'b1);
        check("single_id", res_id, 1'b0);
        next_cycle();

        // Fairness: pointer now at 1, so grants alternate 10,01,...
        req = 2'b11;
        a_bus[0 +: W] = 64'h100;  b_bus[0 +: W] = 64'h1;
        a_bus[W +: W] = 64'h200;  b_bus[W +: W] = 64'h2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fair_gnt", gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) begin
                check("fair_id", res_id, ((i - 1) % 2 == 0) ? 1'b1 : 1'b0);
                check("fair_res", res, ((i - 1) % 2 == 0) ? 64'h202 : 64'h101);
            end
            next_cycle();
        end

        // Negative wrap on requester 0 then backpressure on requester 1.
        req = 2'b01;
        a_bus[0 +: W] = 64'h10;
        b_bus[0 +: W] = 64'hFFFF_FFFF_FFFF_FFE0;
        @(negedge clk);
        check("wrapneg_gnt", gnt, 2'b01);
        next_cycle();
        req       = 2'b10;
        a_bus[W +: W] = 64'hFFFF_FFFF_FFFF_FFFC;
        b_bus[W +: W] = 64'h8;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_gnt", gnt, 2'b00);
            check("bp_res", res, 64'hFFFF_FFFF_FFFF_FFF0);
            check("bp_id", res_id, 1'b0);
            check("bp_valid", res_valid, 1'b1);
            next_cycle();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_gnt", gnt, 2'b10);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        check("wrappos_res", res, 64'h4);
        check("wrappos_id", res_id, 1'b1);
        next_cycle();

        // Reset mid-operation with a held result and ptr=1.
        req = 2'b01;
        a_bus[0 +: W] = 64'h5;
        b_bus[0 +: W] = 64'h6;
        @(negedge clk);
        check("mid_gnt", gnt, 2'b01);
        next_cycle();
        req       = 2'b00;
        res_ready = 1'b0;
        @(negedge clk);
        check("mid_res", res, 64'hB);
        check("mid_ptr", dbg_ptr, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        req   = 2'b11;
        @(negedge clk);
        check("mid_rst_gnt", gnt, 2'b00);
        next_cycle();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", gnt, 2'b01);
        check("post_rst_valid", res_valid, 1'b0);
        check("post_rst_ptr", dbg_ptr, 1'b0);
        next_cycle();

        // Random traffic obeying the hold-until-granted rule.
        prev_rst_low = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] || last_gnt[k] || prev_rst_low) begin
                    req[k]        = 1'($urandom_range(0, 1));
                    a_bus[k*W +: W] = rand64();
                    b_bus[k*W +: W] = rand64();
                end
            end
            prev_rst_low = !rst_n;
            next_cycle();
        end

        rst_n     = 1'b1;
        req       = '0;
        res_ready = 1'b1;
        repeat (3) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
